// File: rtl/fp_cast_arbiter.sv
// Round-robin arbiter sharing one float<->int cast unit among NUM_REQ requesters,
// with tag-routed one-entry result buffers. Optional counters: FP_CAST_ARB_STATS_EN.
module fp_cast_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
   parameter int unsigned FP_WIDTH   = 32,
   parameter int unsigned RND_WIDTH  = 3,
   parameter int unsigned STAT_WIDTH = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ-1:0]                   f2i_i,
   input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]     opa_i,
   input  logic [NUM_REQ-1:0][RND_WIDTH-1:0]    rnd_i,
   output logic [NUM_REQ-1:0]                   gnt_o,
   output logic [NUM_REQ-1:0]                   rvalid_o,
   input  logic [NUM_REQ-1:0]                   rready_i,
   output logic [NUM_REQ-1:0][FP_WIDTH-1:0]     res_o,
   output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]   status_o,
   output logic                                 cast_en_o,
   output logic                                 cast_f2i_o,
   output logic [FP_WIDTH-1:0]                  cast_opa_o,
   output logic [RND_WIDTH-1:0]                 cast_rnd_o,
   output logic [ID_WIDTH-1:0]                  cast_tag_o,
   input  logic                                 cast_valid_i,
   input  logic [ID_WIDTH-1:0]                  cast_tag_i,
   input  logic [FP_WIDTH-1:0]                  cast_res_i,
   input  logic [STAT_WIDTH-1:0]                cast_status_i,
`ifdef FP_CAST_ARB_STATS_EN
   input  logic                                 stat_clr_i,
   output logic [31:0]                          stat_grants_o,
   output logic [31:0]                          stat_conflicts_o,
`endif
   output logic                                 err_o
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} st_e;

   st_e                               st_q [NUM_REQ];
   logic [ID_WIDTH-1:0]               rr_q;
   logic [NUM_REQ-1:0][FP_WIDTH-1:0]  res_q;
   logic [NUM_REQ-1:0][STAT_WIDTH-1:0] stat_q;
   logic                              err_q;

   logic [NUM_REQ-1:0]  elig_c;
   logic [NUM_REQ-1:0]  gnt_c;
   logic                gnt_any_c;
   logic [ID_WIDTH-1:0] gnt_idx_c;
   logic [ID_WIDTH-1:0] rr_nxt_c;
   logic                tag_ok_c;
   logic                ret_ok_c;
   logic [NUM_REQ-1:0]  ret_hit_c;

   // Eligibility and round-robin scan starting at rr_q; no grants during reset.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      gnt_any_c = 1'b0;
      gnt_idx_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         elig_c[k]  = req_i[k] && (st_q[k] == ST_IDLE) && !rst_i;
         rvalid_o[k] = (st_q[k] == ST_DONE);
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_q) + i) % NUM_REQ;
         if (!gnt_any_c && elig_c[ID_WIDTH'(idx)]) begin
            gnt_any_c = 1'b1;
            gnt_idx_c = ID_WIDTH'(idx);
         end
      end
      gnt_c    = gnt_any_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;
      rr_nxt_c = (32'(gnt_idx_c) + 1 == NUM_REQ) ? '0 : gnt_idx_c + ID_WIDTH'(1);
   end

   // A zero-latency cast unit returns in the grant cycle, so a tag being granted counts as busy.
   always_comb begin
      tag_ok_c = 32'(cast_tag_i) < NUM_REQ;
      ret_ok_c = cast_valid_i && tag_ok_c &&
                 ((st_q[cast_tag_i] == ST_BUSY) || (gnt_any_c && (gnt_idx_c == cast_tag_i)));
      for (int unsigned k = 0; k < NUM_REQ; k++)
         ret_hit_c[k] = ret_ok_c && (cast_tag_i == ID_WIDTH'(k));
   end

   always_comb begin
      cast_en_o  = gnt_any_c;
      cast_f2i_o = 1'b0;
      cast_opa_o = '0;
      cast_rnd_o = '0;
      cast_tag_o = '0;
      if (gnt_any_c) begin
         cast_f2i_o = f2i_i[gnt_idx_c];
         cast_opa_o = opa_i[gnt_idx_c];
         cast_rnd_o = rnd_i[gnt_idx_c];
         cast_tag_o = gnt_idx_c;
      end
   end

   // Per-requester IDLE -> BUSY -> DONE -> IDLE state, buffers and sticky error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) st_q[k] <= ST_IDLE;
         rr_q   <= '0;
         res_q  <= '0;
         stat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (gnt_any_c) rr_q <= rr_nxt_c;
         if (cast_valid_i && !ret_ok_c) err_q <= 1'b1;
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ret_hit_c[k]) begin
               res_q[k]  <= cast_res_i;
               stat_q[k] <= cast_status_i;
            end
            case (st_q[k])
               ST_IDLE: if (gnt_c[k]) st_q[k] <= ret_hit_c[k] ? ST_DONE : ST_BUSY;
               ST_BUSY: if (ret_hit_c[k]) st_q[k] <= ST_DONE;
               ST_DONE: if (rready_i[k]) st_q[k] <= ST_IDLE;
               default: st_q[k] <= ST_IDLE;
            endcase
         end
      end
   end

   assign gnt_o    = gnt_c;
   assign res_o    = res_q;
   assign status_o = stat_q;
   assign err_o    = err_q;

`ifdef FP_CAST_ARB_STATS_EN
   logic [31:0] grants_q;
   logic [31:0] conflicts_q;
   logic        multi_c;

   assign multi_c = (elig_c & (elig_c - NUM_REQ'(1))) != '0;

   // Saturating counters; clear wins over increment.
   always_ff @(posedge clk_i) begin
      if (rst_i || stat_clr_i) begin
         grants_q    <= '0;
         conflicts_q <= '0;
      end else begin
         if (gnt_any_c && (grants_q != 32'hFFFF_FFFF)) grants_q <= grants_q + 32'd1;
         if (multi_c && (conflicts_q != 32'hFFFF_FFFF)) conflicts_q <= conflicts_q + 32'd1;
      end
   end

   assign stat_grants_o    = grants_q;
   assign stat_conflicts_o = conflicts_q;
`endif

endmodule
